// File: rtl/knn_dist_batcher.sv
// knn_dist_batcher: groups a stream of 32-bit kNN distances into 17-entry
// batches for the downstream sort17 network. Short batches (closed early by
// in_last) are padded with PAD_VAL so padding sorts into the largest slots.
// A closed batch is held stable under a valid/ready handshake.
module knn_dist_batcher #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       N       = 17,
  parameter logic [DATA_W-1:0] PAD_VAL = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data [N],
  output logic [4:0]        out_count,
  output logic              out_last,
  output logic [15:0]       batch_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q;
  logic [4:0]        fill_q;
  logic [DATA_W-1:0] slot_q [N];
  logic              in_ready_q;
  logic              out_valid_q;
  logic [4:0]        out_count_q;
  logic              out_last_q;
  logic [15:0]       batch_cnt_q;
  logic [15:0]       batch_cnt_d;

  // Saturating increment of the emitted-batch counter.
  always_comb begin
    batch_cnt_d = batch_cnt_q;
    if (batch_cnt_q != '1) begin
      batch_cnt_d = batch_cnt_q + 16'd1;
    end
  end

  // Batch FSM: FILL accepts beats into slots, HOLD presents the batch until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      fill_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      batch_cnt_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        slot_q[i] <= PAD_VAL;
      end
    end else if (clear) begin
      // Flush wins over any beat or handshake in the same cycle.
      state_q     <= FILL;
      fill_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      batch_cnt_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        slot_q[i] <= PAD_VAL;
      end
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            slot_q[fill_q] <= in_data;
            fill_q         <= fill_q + 5'd1;
            if (fill_q == 5'(N - 1) || in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_count_q <= fill_q + 5'd1;
              out_last_q  <= in_last;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            // Slots are re-padded here so the next batch starts clean.
            state_q     <= FILL;
            fill_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            batch_cnt_q <= batch_cnt_d;
            for (int unsigned i = 0; i < N; i++) begin
              slot_q[i] <= PAD_VAL;
            end
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = slot_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign batch_cnt = batch_cnt_q;

endmodule
